alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle ALU. Successor to the single-cycle combinational ALU in the execute stage.
- Adds iterative MUL/DIVU/REMU, a registered result, and valid/ready handshakes on input and output.
- Defines C/V flags precisely for ADD and SUB.
- Sits between operand-select mux and writeback; execute stage stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits used from rdb (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- nrst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; drops any op in flight.
- in_valid  in  1  operands/fop valid this cycle.
- in_ready  out  1  block can accept an op.
- rda  in  WIDTH  operand A.
- rdb  in  WIDTH  operand B (register or immediate, selected upstream).
- fop  in  4  0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 XOR, 8 IMM (pass rdb), 9 MUL (low WIDTH bits), 10 DIVU, 11 REMU; 12-15 illegal.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- Z, N, C, V  out  1 each  registered flags.
- illegal  out  1  registered; high with out_valid when fop was 12-15.

Behaviour:
- Reset (nrst=0, async): state=IDLE; out_valid=0; result=0; Z=N=C=V=illegal=0; counter=0. in_ready=1 once nrst=1.
- States:
  - IDLE: in_ready=1. Accept on in_valid; latch rda, rdb, fop.
    - Ops 0-8 and 12-15: compute and go to DONE next cycle (latency 1).
    - Ops 9-11: go to BUSY with counter=WIDTH.
  - BUSY: in_ready=0. One iteration per cycle, counter decrements. When counter reaches 1, the final result is written and the FSM goes to DONE. MUL/DIV latency is WIDTH+1 cycles from accept to out_valid.
  - DONE: out_valid=1; result/flags held stable while out_ready=0. On out_ready=1, go to IDLE.
  - No accept in the same cycle as the DONE handshake; in_ready is a pure function of state==IDLE.
- flush=1: next state IDLE, out_valid=0, iteration state discarded. Registered result keeps its old value (don't-care). flush has priority over in_valid/out_ready. Reset beats flush.
- Arithmetic (all WIDTH-bit, wrap modulo 2^WIDTH):
  - Shifts use rdb[SHW-1:0] only. SRA is arithmetic on signed rda.
  - MUL: shift-add, low WIDTH bits of the unsigned product; this equals the signed low word.
  - DIVU/REMU: restoring, unsigned.
  - rdb=0: DIVU result all ones; REMU result rda; no trap.
  - Illegal fop: result=0, illegal=1, flags computed from result 0 (Z=1).
- Flags are registered with the result. Z = (result==0). N = result[WIDTH-1].
  - ADD: C = carry out of bit WIDTH-1; V = (rda[MSB]==rdb[MSB]) && (result[MSB]!=rda[MSB]).
  - SUB: C = 1 when no borrow (rda >= rdb unsigned); V = (rda[MSB]!=rdb[MSB]) && (result[MSB]!=rda[MSB]).
  - All other ops: C=0, V=0.
- in_valid while in_ready=0: ignored; the upstream stage holds its operands.
- No X on outputs after reset under any input sequence.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> out_valid 1 cycle after accept, result 0x80000000, N=1 V=1 C=0 Z=0. ADD 0xFFFFFFFF + 1 -> 0, Z=1 C=1 V=0.
- SUB 5-5 -> 0, Z=1 C=1. SUB 3-5 -> 0xFFFFFFFE, N=1 C=0 V=0. SRA 0x80000000 by rdb=0x21 (amount 1) -> 0xC0000000.
- MUL 0x0000FFFF * 0x0000FFFF -> 0xFFFE0001 with out_valid exactly 33 cycles after accept; in_ready=0 throughout BUSY.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
- Backpressure: complete XOR 0xF0F0F0F0 ^ 0xFFFFFFFF, hold out_ready=0 for 5 cycles -> result 0x0F0F0F0F stable, out_valid=1, in_ready=0. Raise out_ready -> IDLE next cycle.
- Abort: start DIVU, assert flush at BUSY cycle 10 -> IDLE, out_valid never rises, next ADD 2+2 gives 4. Repeat with nrst pulsed low mid-BUSY -> all outputs 0 immediately. Illegal fop 13 -> illegal=1, result 0, Z=1.

Source files
------------

// File: rtl/alu_mc_if.sv
// Handshake and data bundle between the operand-select stage, the
// multi-cycle ALU and writeback.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] rda;
    logic [WIDTH-1:0] rdb;
    logic [3:0]       fop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             Z;
    logic             N;
    logic             C;
    logic             V;
    logic             illegal;

    // ALU side
    modport slave (
        input  in_valid, rda, rdb, fop, out_ready,
        output in_ready, out_valid, result, Z, N, C, V, illegal
    );

    // Execute-stage / driver side
    modport master (
        output in_valid, rda, rdb, fop, out_ready,
        input  in_ready, out_valid, result, Z, N, C, V, illegal
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and
// restoring DIVU/REMU, registered result and flags, valid/ready on both sides.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     nrst,
    input  logic     flush,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH) + 1;
    localparam int MSB = WIDTH - 1;

    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SRL  = 4'd3;
    localparam logic [3:0] OP_SRA  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_IMM  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       op_r;
    logic [CW-1:0]    cnt_r;
    // p_r: MUL accumulator / partial remainder; q_r: shifted multiplicand /
    // dividend-becoming-quotient; d_r: shifted multiplier / divisor.
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] res_r;
    logic             z_r;
    logic             n_r;
    logic             c_r;
    logic             v_r;
    logic             ill_r;

    logic             multi_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   dif_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s;
    logic             alu_v_s;
    logic             alu_ill_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] it_p_s;
    logic [WIDTH-1:0] it_q_s;
    logic [WIDTH-1:0] it_d_s;
    logic [WIDTH-1:0] fin_res_s;

    assign multi_s = (bus.fop == OP_MUL) || (bus.fop == OP_DIVU) || (bus.fop == OP_REMU);

    // State register; flush returns to IDLE, reset beats flush.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else if (flush) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; no accept is possible in the DONE handshake cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nxt_s = multi_s ? ST_BUSY : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s  = 1'b1;
            ST_BUSY: in_ready_s  = 1'b0;
            ST_DONE: out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Single-cycle ops computed straight from the incoming operands.
    always_comb begin
        sum_s     = {1'b0, bus.rda} + {1'b0, bus.rdb};
        dif_s     = {1'b0, bus.rda} - {1'b0, bus.rdb};
        alu_res_s = '0;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        alu_ill_s = 1'b0;
        case (bus.fop)
            OP_ADD: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = (bus.rda[MSB] == bus.rdb[MSB]) && (sum_s[MSB] != bus.rda[MSB]);
            end
            OP_SUB: begin
                alu_res_s = dif_s[WIDTH-1:0];
                alu_c_s   = ~dif_s[WIDTH];
                alu_v_s   = (bus.rda[MSB] != bus.rdb[MSB]) && (dif_s[MSB] != bus.rda[MSB]);
            end
            OP_SLL:  alu_res_s = bus.rda << bus.rdb[SHW-1:0];
            OP_SRL:  alu_res_s = bus.rda >> bus.rdb[SHW-1:0];
            OP_SRA:  alu_res_s = $unsigned($signed(bus.rda) >>> bus.rdb[SHW-1:0]);
            OP_AND:  alu_res_s = bus.rda & bus.rdb;
            OP_OR:   alu_res_s = bus.rda | bus.rdb;
            OP_XOR:  alu_res_s = bus.rda ^ bus.rdb;
            OP_IMM:  alu_res_s = bus.rdb;
            OP_MUL, OP_DIVU, OP_REMU: alu_res_s = '0;
            default: alu_ill_s = 1'b1;
        endcase
    end

    // One shift-add or restoring-division step on the iteration registers.
    always_comb begin
        rem_sh_s = {p_r, q_r[MSB]};
        trial_s  = rem_sh_s - {1'b0, d_r};
        it_p_s   = p_r;
        it_q_s   = q_r;
        it_d_s   = d_r;
        if (op_r == OP_MUL) begin
            it_p_s = p_r + (d_r[0] ? q_r : {WIDTH{1'b0}});
            it_q_s = {q_r[WIDTH-2:0], 1'b0};
            it_d_s = {1'b0, d_r[WIDTH-1:1]};
        end else if (!trial_s[WIDTH]) begin
            // Divisor fits: keep the difference, quotient bit 1. A zero
            // divisor always fits, giving all-ones quotient and rda remainder.
            it_p_s = trial_s[WIDTH-1:0];
            it_q_s = {q_r[WIDTH-2:0], 1'b1};
        end else begin
            it_p_s = rem_sh_s[WIDTH-1:0];
            it_q_s = {q_r[WIDTH-2:0], 1'b0};
        end
    end

    // Select the final multi-cycle result from the last iteration step.
    always_comb begin
        case (op_r)
            OP_MUL:  fin_res_s = it_p_s;
            OP_DIVU: fin_res_s = it_q_s;
            OP_REMU: fin_res_s = it_p_s;
            default: fin_res_s = '0;
        endcase
    end

    // Operand latch, iteration registers, registered result and flags.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            op_r  <= 4'd0;
            cnt_r <= '0;
            p_r   <= '0;
            q_r   <= '0;
            d_r   <= '0;
            res_r <= '0;
            z_r   <= 1'b0;
            n_r   <= 1'b0;
            c_r   <= 1'b0;
            v_r   <= 1'b0;
            ill_r <= 1'b0;
        end else if (flush) begin
            cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && multi_s) begin
                        op_r  <= bus.fop;
                        cnt_r <= CNT_LOAD;
                        p_r   <= '0;
                        q_r   <= bus.rda;
                        d_r   <= bus.rdb;
                    end else if (bus.in_valid) begin
                        res_r <= alu_res_s;
                        z_r   <= (alu_res_s == {WIDTH{1'b0}});
                        n_r   <= alu_res_s[MSB];
                        c_r   <= alu_c_s;
                        v_r   <= alu_v_s;
                        ill_r <= alu_ill_s;
                    end
                end
                ST_BUSY: begin
                    p_r   <= it_p_s;
                    q_r   <= it_q_s;
                    d_r   <= it_d_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        res_r <= fin_res_s;
                        z_r   <= (fin_res_s == {WIDTH{1'b0}});
                        n_r   <= fin_res_s[MSB];
                        c_r   <= 1'b0;
                        v_r   <= 1'b0;
                        ill_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    res_r <= res_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.result    = res_r;
    assign bus.Z         = z_r;
    assign bus.N         = n_r;
    assign bus.C         = c_r;
    assign bus.V         = v_r;
    assign bus.illegal   = ill_r;

endmodule

// File: tb/tb_alu_mc.sv
// Directed scoreboard bench for alu_mc (WIDTH=32).
module tb_alu_mc;
    localparam int W = 32;

    logic clk = 1'b0;
    logic nrst;
    logic flush;
    int   cyc = 0;
    int   drive_cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk   (clk),
        .nrst  (nrst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   fl;    // {Z,N,C,V,illegal}
        int           lat;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, expv);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {bus.Z, bus.N, bus.C, bus.V, bus.illegal};
    endfunction

    // Drive one op for a single accepted cycle, waiting (bounded) for in_ready.
    task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({name, "/ready_before_issue"}, W'(bus.in_ready), W'(1));
        bus.fop      = op;
        bus.rda      = a;
        bus.rdb      = b;
        bus.in_valid = 1'b1;
        drive_cyc    = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, pop the scoreboard, compare, optionally
    // hold back-pressure, then complete the output handshake.
    task automatic collect(input string name, input int hold, input bit chk_busy);
        exp_t e;
        int   t = 0;
        bit   rdy_bad = 1'b0;
        while (bus.out_valid !== 1'b1 && t < 100) begin
            if (bus.in_ready !== 1'b0) rdy_bad = 1'b1;
            @(negedge clk);
            t++;
        end
        chk({name, "/out_valid"}, W'(bus.out_valid), W'(1));
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s/scoreboard: observed empty queue, required an entry", name);
        end else begin
            e = exp_q.pop_front();
            chk({name, "/result"}, bus.result, e.res);
            chk({name, "/flags"}, W'(flags_now()), W'(e.fl));
            chk({name, "/latency"}, W'(cyc - drive_cyc), W'(e.lat));
            if (chk_busy) chk({name, "/busy_in_ready_low"}, W'(rdy_bad), W'(0));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({name, "/bp_valid"}, W'(bus.out_valid), W'(1));
                chk({name, "/bp_result"}, bus.result, e.res);
                chk({name, "/bp_in_ready"}, W'(bus.in_ready), W'(0));
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, "/post_valid"}, W'(bus.out_valid), W'(0));
        chk({name, "/post_in_ready"}, W'(bus.in_ready), W'(1));
    endtask

    task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic [4:0] fl, input int lat, input int hold);
        exp_t e;
        e.res = res;
        e.fl  = fl;
        e.lat = lat;
        exp_q.push_back(e);
        issue(name, op, a, b);
        collect(name, hold, (lat > 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;

        nrst          = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.fop       = 4'd0;
        bus.rda       = 32'h0;
        bus.rdb       = 32'h0;
        repeat (3) @(negedge clk);

        chk("reset/out_valid", W'(bus.out_valid), W'(0));
        chk("reset/result", bus.result, 32'h0);
        chk("reset/flags", W'(flags_now()), W'(0));
        nrst = 1'b1;
        @(negedge clk);
        chk("reset/in_ready", W'(bus.in_ready), W'(1));

        // flags {Z,N,C,V,illegal}
        do_op("add_ovf",   4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010, 1, 0);
        do_op("add_carry", 4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100, 1, 0);
        do_op("sub_eq",    4'd1, 32'h00000005, 32'h00000005, 32'h00000000, 5'b10100, 1, 0);
        do_op("sub_neg",   4'd1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 5'b01000, 1, 0);
        do_op("sub_ovf",   4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00110, 1, 0);
        do_op("sra",       4'd4, 32'h80000000, 32'h00000021, 32'hC0000000, 5'b01000, 1, 0);
        do_op("sll",       4'd2, 32'h00000001, 32'h00000024, 32'h00000010, 5'b00000, 1, 0);
        do_op("srl",       4'd3, 32'h80000000, 32'h0000001F, 32'h00000001, 5'b00000, 1, 0);
        do_op("and",       4'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 5'b00000, 1, 0);
        do_op("or",        4'd6, 32'hF0000000, 32'h0000000F, 32'hF000000F, 5'b01000, 1, 0);
        do_op("imm",       4'd8, 32'h12345678, 32'h00ABCDEF, 32'h00ABCDEF, 5'b00000, 1, 0);

        do_op("mul",       4'd9,  32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 5'b01000, 33, 0);
        do_op("divu",      4'd10, 32'd100,      32'd7,        32'd14,       5'b00000, 33, 0);
        do_op("remu",      4'd11, 32'd100,      32'd7,        32'd2,        5'b00000, 33, 0);
        do_op("divu_zero", 4'd10, 32'd9,        32'd0,        32'hFFFFFFFF, 5'b01000, 33, 0);
        do_op("remu_zero", 4'd11, 32'd9,        32'd0,        32'd9,        5'b00000, 33, 0);

        do_op("xor_bp",    4'd7, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 5'b00000, 1, 5);

        // Abort a DIVU partway through BUSY with flush.
        issue("flush_div", 4'd10, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush/in_ready", W'(bus.in_ready), W'(1));
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
            @(negedge clk);
        end
        chk("flush/out_valid_never", W'(seen_valid), W'(0));
        do_op("add_after_flush", 4'd0, 32'd2, 32'd2, 32'd4, 5'b00000, 1, 0);

        // Asynchronous reset in the middle of a MUL.
        issue("rst_mul", 4'd9, 32'h00001234, 32'h00005678);
        repeat (5) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("midrst/result", bus.result, 32'h0);
        chk("midrst/flags", W'(flags_now()), W'(0));
        chk("midrst/out_valid", W'(bus.out_valid), W'(0));
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("midrst/in_ready", W'(bus.in_ready), W'(1));
        do_op("add_after_rst", 4'd0, 32'd2, 32'd2, 32'd4, 5'b00000, 1, 0);

        do_op("illegal13", 4'd13, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b10001, 1, 0);

        chk("scoreboard_drained", W'(exp_q.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
